multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Control FSM for the multi-cycle MIPS-subset datapath. Sequences the shared register file, ALU, memory port, instruction register and 16→32-bit immediate extender across FETCH/DECODE/EXECUTE/MEM/WRITEBACK cycles. Decodes `opcode`/`funct` from the IR, selects sign- vs zero-extension of the immediate, and stalls on a memory ready handshake.

## Interface
- No parameters.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag (combinational, current cycle)
- `mem_ready`  in  1  memory has completed the current read/write this cycle
- `pc_we`  out  1  PC write enable
- `ir_we`  out  1  IR write enable
- `mem_re`, `mem_we`  out  1 each  memory read / write request
- `reg_we`  out  1  register file write enable
- `mem_addr_sel`  out  1  memory address source: 0 = PC, 1 = ALUOut
- `reg_dst`  out  2  write register: 0 = rt, 1 = rd, 2 = r31
- `wb_sel`  out  2  writeback data: 0 = ALUOut, 1 = MDR, 2 = PC
- `alu_a_sel`  out  1  ALU A input: 0 = PC, 1 = rs
- `alu_b_sel`  out  2  ALU B input: 0 = rt, 1 = const 4, 2 = ext(imm), 3 = ext(imm)<<2
- `ext_zero`  out  1  extender mode: 1 = zero-extend, 0 = sign-extend
- `alu_op`  out  3  0 = ADD, 1 = SUB, 2 = XOR, 3 = SLT
- `pc_src`  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target {PC[31:28], IR[25:0], 2'b00}, 3 = rs
- `state`  out  4  current state encoding (debug)
- `trap`  out  1  sticky illegal-instruction flag

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, ALU_WB 7, EXEC_I 8, BRANCH 9, JUMP 10, TRAP 11.
- All outputs are Moore functions of `state`. Exceptions: `pc_we` in FETCH and BRANCH, the DECODE next-state, and `alu_op` in EXEC_R, which use the listed inputs.
- Default for any unlisted output: 0. `ext_zero` = 0 except in EXEC_I for XORI.
- FETCH:
  - Drives `mem_re` = 1, `mem_addr_sel` = 0, `alu_a_sel` = 0, `alu_b_sel` = 1, `pc_src` = 0.
  - `ir_we` = `pc_we` = `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE:
  - Drives `alu_a_sel` = 0, `alu_b_sel` = 3, `alu_op` = ADD, precomputing the branch target into ALUOut.
  - Next state by opcode:
    - 0x23 LW, 0x2B SW → MEM_ADDR
    - 0x00 with funct 0x20/0x22/0x2A → EXEC_R; funct 0x08 (JR) → JUMP
    - 0x08 ADDI, 0x0E XORI → EXEC_I
    - 0x04 BEQ, 0x05 BNE → BRANCH
    - 0x02 J, 0x03 JAL → JUMP
    - any other opcode/funct → TRAP
- MEM_ADDR: A = rs, B = ext(imm) sign-extended, ADD. Goes to MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: `mem_re` = 1, `mem_addr_sel` = 1. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_we` = 1, `reg_dst` = 0, `wb_sel` = 1. Goes to FETCH.
- MEM_WRITE: `mem_we` = 1, `mem_addr_sel` = 1. Holds until `mem_ready`, then goes to FETCH.
- EXEC_R: A = rs, B = rt. `alu_op` from funct: 0x20 ADD, 0x22 SUB, 0x2A SLT. Goes to ALU_WB.
- ALU_WB: `reg_we` = 1, `wb_sel` = 0, `reg_dst` = 1 for R-type, 0 for I-type. Goes to FETCH.
- EXEC_I: A = rs, B = ext(imm). ADDI uses ADD with sign extension. XORI uses XOR with `ext_zero` = 1. Goes to ALU_WB.
- BRANCH:
  - A = rs, B = rt, SUB, `pc_src` = 1.
  - `pc_we` = `zero` for BEQ, `pc_we` = !`zero` for BNE.
  - Goes to FETCH.
- JUMP:
  - `pc_we` = 1. `pc_src` = 3 for JR, else 2.
  - JAL additionally drives `reg_we` = 1, `reg_dst` = 2, `wb_sel` = 2, using the PC already incremented in FETCH.
  - Goes to FETCH.
- TRAP: all enables 0 and `trap` = 1. Stays in TRAP until reset.
- Opcode/funct are held in an internal register captured when `ir_we` = 1. Later states decode from this captured copy, not from the live inputs.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `state` = FETCH, `trap` = 0, captured opcode/funct = 0.
  - While `rst_n` = 0, all enables (`pc_we`, `ir_we`, `mem_re`, `mem_we`, `reg_we`) are forced to 0.
- The first fetch request appears in the first cycle after `rst_n` deasserts.
- Cycles per instruction with `mem_ready` held at 1:
  - R-type / ADDI / XORI: 4
  - LW: 5
  - SW: 4
  - BEQ / BNE / J / JAL / JR: 3
- Each cycle `mem_ready` is 0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Request outputs stay asserted and stable throughout the stall.
- Reset asserted mid-instruction aborts it immediately. No partial write is issued after reset asserts.

## Configuration
- `MCCTRL_PERF_EN` defined:
  - Adds output `cycle_cnt` (32 bits), incremented every cycle while not in reset and not in TRAP.
  - Adds output `instr_cnt` (32 bits), incremented on every transition into FETCH from another state.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: neither port exists, and no counter logic is built.

## Test plan
- ADD (op 0x00, funct 0x20) with `mem_ready` = 1:
  - Expected state sequence 0→1→6→7→0.
  - `reg_we` = 1 only in cycle 4, with `reg_dst` = 1 and `alu_op` = 0 in cycle 3.
- LW with `mem_ready` low for 2 cycles in MEM_READ:
  - 7 cycles total.
  - `mem_re` and `mem_addr_sel` = 1 held stable through the stall.
  - `reg_we` = 1 with `wb_sel` = 1 in MEM_WB.
- BEQ with `zero` = 1 → `pc_we` = 1, `pc_src` = 1 in BRANCH. BNE with `zero` = 1 → `pc_we` = 0.
- XORI (0x0E) → `ext_zero` = 1, `alu_b_sel` = 2, `alu_op` = 2 in EXEC_I. ADDI (0x08) → `ext_zero` = 0.
- JAL → in JUMP: `pc_src` = 2, `reg_dst` = 2, `wb_sel` = 2, `reg_we` = 1. Opcode 0x3F → TRAP, `trap` = 1, no enables asserted until `rst_n` pulses.
- `rst_n` pulled low during MEM_WRITE → `mem_we` drops to 0 asynchronously and `state` = 0. With `MCCTRL_PERF_EN`, `cycle_cnt` = 0 and `instr_cnt` = 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multi-cycle MIPS-subset datapath.
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and stalls on mem_ready.
// Optional feature macro: MCCTRL_PERF_EN adds cycle_cnt/instr_cnt counters.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        reg_we,
    output logic        mem_addr_sel,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic        ext_zero,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [3:0]  state,
    output logic        trap
`ifdef MCCTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_TRAP      = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;

    state_e     state_q, state_d;
    logic [5:0] irOp_q, irFunct_q;
    logic       trap_q;

    logic pcWeRaw, irWeRaw, memReRaw, memWeRaw, regWeRaw;

    // State register; reset returns to FETCH and abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Private copy of opcode/funct taken with the IR so later states ignore the live IR bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irOp_q    <= 6'd0;
            irFunct_q <= 6'd0;
        end else if (irWeRaw) begin
            irOp_q    <= opcode;
            irFunct_q <= funct;
        end
    end

    // Sticky illegal-instruction flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_q | (state_d == S_TRAP);
        end
    end

    // Next-state and Moore datapath controls, every output defaulted before the state case
    always_comb begin
        state_d      = state_q;
        pcWeRaw      = 1'b0;
        irWeRaw      = 1'b0;
        memReRaw     = 1'b0;
        memWeRaw     = 1'b0;
        regWeRaw     = 1'b0;
        mem_addr_sel = 1'b0;
        reg_dst      = 2'd0;
        wb_sel       = 2'd0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 2'd0;
        ext_zero     = 1'b0;
        alu_op       = ALU_ADD;
        pc_src       = 2'd0;
        case (state_q)
            S_FETCH: begin
                memReRaw  = 1'b1;
                alu_b_sel = 2'd1;
                irWeRaw   = mem_ready;
                pcWeRaw   = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_b_sel = 2'd3;
                case (irOp_q)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_ADDI, OP_XORI: state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J, OP_JAL:     state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (irFunct_q == FN_ADD || irFunct_q == FN_SUB || irFunct_q == FN_SLT) begin
                            state_d = S_EXEC_R;
                        end else if (irFunct_q == FN_JR) begin
                            state_d = S_JUMP;
                        end else begin
                            state_d = S_TRAP;
                        end
                    end
                    default:          state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_a_sel = 1'b1;
                alu_b_sel = 2'd2;
                state_d   = (irOp_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                memReRaw     = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                regWeRaw = 1'b1;
                wb_sel   = 2'd1;
                state_d  = S_FETCH;
            end
            S_MEM_WRITE: begin
                memWeRaw     = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_a_sel = 1'b1;
                case (irFunct_q)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                regWeRaw = 1'b1;
                reg_dst  = (irOp_q == OP_RTYPE) ? 2'd1 : 2'd0;
                state_d  = S_FETCH;
            end
            S_EXEC_I: begin
                alu_a_sel = 1'b1;
                alu_b_sel = 2'd2;
                if (irOp_q == OP_XORI) begin
                    ext_zero = 1'b1;
                    alu_op   = ALU_XOR;
                end
                state_d = S_ALU_WB;
            end
            S_BRANCH: begin
                alu_a_sel = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'd1;
                pcWeRaw   = (irOp_q == OP_BEQ) ? zero : ~zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pcWeRaw = 1'b1;
                pc_src  = (irOp_q == OP_RTYPE) ? 2'd3 : 2'd2;
                if (irOp_q == OP_JAL) begin
                    regWeRaw = 1'b1;
                    reg_dst  = 2'd2;
                    wb_sel   = 2'd2;
                end
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    assign pc_we  = pcWeRaw  & rst_n;
    assign ir_we  = irWeRaw  & rst_n;
    assign mem_re = memReRaw & rst_n;
    assign mem_we = memWeRaw & rst_n;
    assign reg_we = regWeRaw & rst_n;
    assign state  = state_q;
    assign trap   = trap_q;

`ifdef MCCTRL_PERF_EN
    logic [31:0] cycleCnt_q, instrCnt_q;

    // Performance counters: live cycles outside TRAP, and completed instructions (returns to FETCH)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycleCnt_q <= 32'd0;
            instrCnt_q <= 32'd0;
        end else begin
            if (state_q != S_TRAP) begin
                cycleCnt_q <= cycleCnt_q + 32'd1;
            end
            if (state_q != S_FETCH && state_d == S_FETCH) begin
                instrCnt_q <= instrCnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycleCnt_q;
    assign instr_cnt = instrCnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed plus randomized instruction streams checked
// cycle by cycle against a per-instruction phase-schedule model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ready;
    logic        pc_we, ir_we, mem_re, mem_we, reg_we, mem_addr_sel;
    logic [1:0]  reg_dst, wb_sel;
    logic        alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic        ext_zero;
    logic [2:0]  alu_op;
    logic [1:0]  pc_src;
    logic [3:0]  state;
    logic        trap;
`ifdef MCCTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int          nChecks = 0;
    int          nErrors = 0;
    logic [31:0] cycleModel = 32'd0;
    logic [31:0] instrModel = 32'd0;
    int          lastCycles;
    logic [23:0] obs;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .mem_re(mem_re), .mem_we(mem_we),
        .reg_we(reg_we), .mem_addr_sel(mem_addr_sel), .reg_dst(reg_dst),
        .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .ext_zero(ext_zero), .alu_op(alu_op), .pc_src(pc_src),
        .state(state), .trap(trap)
`ifdef MCCTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {state, pc_we, ir_we, mem_re, mem_we, reg_we, mem_addr_sel,
                  reg_dst, wb_sel, alu_a_sel, alu_b_sel, ext_zero, alu_op, pc_src, trap};

    // Expected control bundle for one cycle of a phase, written from the per-state output table
    function automatic logic [23:0] expOut(input int ph, input logic [5:0] op, input logic [5:0] fn,
                                           input logic z, input logic rdy, input logic inRst);
        logic pcWe = 0, irWe = 0, memRe = 0, memWe = 0, regWe = 0, addrSel = 0;
        logic [1:0] regDst = 0, wbSel = 0, bSel = 0, pcSrc = 0;
        logic aSel = 0, extZ = 0, trp = 0;
        logic [2:0] aluOp = 0;
        case (ph)
            0:  begin memRe = 1; bSel = 1; irWe = rdy; pcWe = rdy; end
            1:  bSel = 3;
            2:  begin aSel = 1; bSel = 2; end
            3:  begin memRe = 1; addrSel = 1; end
            4:  begin regWe = 1; wbSel = 1; end
            5:  begin memWe = 1; addrSel = 1; end
            6:  begin aSel = 1; aluOp = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0; end
            7:  begin regWe = 1; regDst = (op == 6'h00) ? 2'd1 : 2'd0; end
            8:  begin aSel = 1; bSel = 2; if (op == 6'h0E) begin extZ = 1; aluOp = 3'd2; end end
            9:  begin aSel = 1; aluOp = 3'd1; pcSrc = 1; pcWe = (op == 6'h04) ? z : !z; end
            10: begin
                    pcWe = 1; pcSrc = (op == 6'h00) ? 2'd3 : 2'd2;
                    if (op == 6'h03) begin regWe = 1; regDst = 2; wbSel = 2; end
                end
            11: trp = 1;
            default: ;
        endcase
        if (inRst) begin
            pcWe = 0; irWe = 0; memRe = 0; memWe = 0; regWe = 0;
        end
        return {4'(ph), pcWe, irWe, memRe, memWe, regWe, addrSel, regDst, wbSel,
                aSel, bSel, extZ, aluOp, pcSrc, trp};
    endfunction

    // Compare the whole control bundle (and counters when built) against expectations
    task automatic checkOutput(input string tag, input logic [23:0] expv);
        nChecks++;
        assert (obs === expv) else begin
            nErrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
`ifdef MCCTRL_PERF_EN
        nChecks++;
        assert (cycle_cnt === cycleModel) else begin
            nErrors++;
            $error("FAIL %s_cycle_cnt: observed %0d expected %0d", tag, cycle_cnt, cycleModel);
        end
        nChecks++;
        assert (instr_cnt === instrModel) else begin
            nErrors++;
            $error("FAIL %s_instr_cnt: observed %0d expected %0d", tag, instr_cnt, instrModel);
        end
`endif
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Run one instruction from FETCH; abortPh >= 0 pulls reset mid-cycle in that phase
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input int fStall,
                                 input int mStall, input int zmode, input int abortPh);
        int phases[$];
        int idx = 0;
        int stall = 0;
        int ph;
        lastCycles = 0;
        case (op)
            6'h23:        phases = '{0, 1, 2, 3, 4};
            6'h2B:        phases = '{0, 1, 2, 5};
            6'h08, 6'h0E: phases = '{0, 1, 8, 7};
            6'h04, 6'h05: phases = '{0, 1, 9};
            6'h02, 6'h03: phases = '{0, 1, 10};
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) phases = '{0, 1, 6, 7};
                else if (fn == 6'h08)                           phases = '{0, 1, 10};
                else                                            phases = '{0, 1, 11};
            end
            default:      phases = '{0, 1, 11};
        endcase
        while (idx < phases.size()) begin
            ph = phases[idx];
            if (ph <= 1) begin
                opcode = op; funct = fn;
            end else begin
                opcode = 6'($urandom); funct = 6'($urandom);
            end
            if (ph == 0)                 mem_ready = (stall >= fStall);
            else if (ph == 3 || ph == 5) mem_ready = (stall >= mStall);
            else                         mem_ready = 1'($urandom);
            zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            @(negedge clk);
            checkOutput($sformatf("op%02h_fn%02h_ph%0d_c%0d", op, fn, ph, lastCycles),
                        expOut(ph, op, fn, zero, mem_ready, 1'b0));
            if (ph == abortPh) begin
                #1 rst_n = 1'b0;
                #1;
                cycleModel = 0; instrModel = 0;
                checkOutput("abort_reset", expOut(0, 6'd0, 6'd0, zero, mem_ready, 1'b1));
                return;
            end
            @(posedge clk);
            #1;
            lastCycles++;
            if (ph != 11) cycleModel++;
            if ((ph == 0 || ph == 3 || ph == 5) && !mem_ready) begin
                stall++;
            end else begin
                idx++;
                stall = 0;
                if (idx == phases.size() && ph != 11) instrModel++;
            end
        end
    endtask

    // Hold in TRAP for a few cycles with random inputs, then pulse reset and recover
    task automatic trapAndRecover(input string tag);
        repeat (4) begin
            opcode = 6'($urandom); funct = 6'($urandom);
            zero = 1'($urandom); mem_ready = 1'($urandom);
            @(negedge clk);
            checkOutput({tag, "_hold"}, expOut(11, opcode, funct, zero, mem_ready, 1'b0));
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        cycleModel = 0; instrModel = 0;
        checkOutput({tag, "_reset"}, expOut(0, 6'd0, 6'd0, zero, mem_ready, 1'b1));
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [11:0] legal [12] = '{
        {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h2A}, {6'h00, 6'h08},
        {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h08, 6'h00}, {6'h0E, 6'h00},
        {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}
    };

    initial begin
        logic [11:0] pick;
        logic [5:0]  rfn;
        rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;

        // Reset: FETCH encoding, no enables even with mem_ready high
        repeat (3) begin
            @(posedge clk);
            #1 mem_ready = 1'($urandom);
            @(negedge clk);
            checkOutput("reset", expOut(0, 6'd0, 6'd0, zero, mem_ready, 1'b1));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed instructions
        applyStimulus(6'h00, 6'h20, 0, 0, 2, -1);
        checkCount("add_cycles", lastCycles, 4);
        applyStimulus(6'h23, 6'h11, 0, 2, 2, -1);
        checkCount("lw_stall_cycles", lastCycles, 7);
        applyStimulus(6'h23, 6'h00, 0, 0, 2, -1);
        checkCount("lw_cycles", lastCycles, 5);
        applyStimulus(6'h2B, 6'h00, 1, 1, 2, -1);
        checkCount("sw_stall_cycles", lastCycles, 6);
        applyStimulus(6'h04, 6'h00, 0, 0, 1, -1);
        applyStimulus(6'h05, 6'h00, 0, 0, 1, -1);
        applyStimulus(6'h04, 6'h00, 0, 0, 0, -1);
        applyStimulus(6'h05, 6'h00, 0, 0, 0, -1);
        checkCount("bne_cycles", lastCycles, 3);
        applyStimulus(6'h0E, 6'h3F, 0, 0, 2, -1);
        applyStimulus(6'h08, 6'h3F, 0, 0, 2, -1);
        applyStimulus(6'h03, 6'h00, 0, 0, 2, -1);
        applyStimulus(6'h02, 6'h15, 2, 0, 2, -1);
        applyStimulus(6'h00, 6'h08, 0, 0, 2, -1);
        applyStimulus(6'h00, 6'h22, 0, 0, 2, -1);
        applyStimulus(6'h00, 6'h2A, 0, 0, 2, -1);

        // Randomized legal instruction stream with random stalls
        for (int i = 0; i < 60; i++) begin
            pick = legal[$urandom_range(11, 0)];
            rfn  = (pick[11:6] == 6'h00) ? pick[5:0] : 6'($urandom);
            applyStimulus(pick[11:6], rfn, $urandom_range(2, 0), $urandom_range(3, 0), 2, -1);
        end

        // Reset pulled during a stalled MEM_WRITE
        applyStimulus(6'h2B, 6'h00, 0, 3, 2, 5);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(6'h00, 6'h20, 0, 0, 2, -1);

        // Illegal opcode and illegal R-type funct both trap until reset
        applyStimulus(6'h3F, 6'h20, 0, 0, 2, -1);
        trapAndRecover("trap_op3f");
        applyStimulus(6'h00, 6'h21, 1, 0, 2, -1);
        trapAndRecover("trap_fn21");
        applyStimulus(6'h08, 6'h00, 0, 0, 2, -1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
